dat_xfer_seq: RTL and testbench

Parametrised multi-block data-transfer sequencer for the SDHCI data path, the successor to the fixed read/write DAT controller. It sequences block reader/writer engines against buffer availability and counts blocks. It adds infinite (uncounted) transfers, stop-at-block-gap / continue, selectable bus width up to 8 lanes, and per-transfer error pulses. It sits between the register file and the dat_read/dat_write/dat_buffer instances.

---
 rtl/dat_xfer_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dat_xfer_seq.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_xfer_seq.sv
// Purpose: multi-block SD data-transfer sequencer; paces block engines against buffer state and counts blocks.
// Latency: all outputs registered, one clk_i after the qualifying input (lane_mask_o is combinational from bus_width_i).
// Backpressure: holds in WAIT_BUF until the buffer can take/give a block; a read that stalls pauses the SD clock.
// Optional: define DAT_XFER_BUSY_WAIT_EN to hold a finished write in BUSY until DAT0 is released.
module dat_xfer_seq #(
    parameter int MaxLanes      = 4,
    parameter int BlockCntWidth = 16,
    parameter int TimeoutWidth  = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sd_clk_en_p_i,
    input  logic                     xfer_req_i,
    input  logic                     dir_read_i,
    input  logic                     block_count_en_i,
    input  logic [BlockCntWidth-1:0] block_count_i,
    input  logic [1:0]               bus_width_i,
    input  logic                     auto_cmd12_en_i,
    input  logic                     stop_at_gap_i,
    input  logic                     continue_i,
    input  logic                     abort_i,
    input  logic                     cmd_done_i,
    input  logic                     rsp_done_i,
    input  logic [TimeoutWidth-1:0]  timeout_limit_i,
    input  logic                     buf_space_i,
    input  logic                     buf_block_i,
    input  logic                     buf_empty_i,
    input  logic                     dat0_i,
    output logic                     blk_start_o,
    input  logic                     blk_done_i,
    input  logic                     blk_crc_err_i,
    input  logic                     blk_end_err_i,
    output logic [MaxLanes-1:0]      lane_mask_o,
    output logic                     pause_sd_clk_o,
    output logic                     request_cmd12_o,
    output logic                     read_active_o,
    output logic                     write_active_o,
    output logic                     gap_stopped_o,
    output logic                     xfer_done_o,
    output logic                     crc_err_o,
    output logic                     end_bit_err_o,
    output logic                     timeout_err_o,
    output logic [BlockCntWidth-1:0] blocks_left_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_CMD,
        S_WAIT_BUF,
        S_START,
        S_XFER,
        S_BLK_DONE,
        S_GAP_STOP,
        S_DRAIN,
        S_BUSY,
        S_TIMEOUT,
        S_DONE
    } state_t;

    state_t                  state;
    logic                    dir_q;       // latched direction, 1 = read
    logic                    cnt_en_q;    // latched counted/infinite select
    logic                    blk_seen_q;  // at least one block finished in this transfer
    logic [TimeoutWidth-1:0] tmo_lim_q;
    logic [TimeoutWidth-1:0] tmo_cnt;
    logic [TimeoutWidth:0]   tmo_nxt;
    logic                    tmo_hit;
    logic                    buf_ok;
    logic                    is_last;

    // Lane mask: requested width clamped to what this instance supports; code 3 means widest.
    always_comb begin
        int n_lanes;
        n_lanes = 1;
        case (bus_width_i)
            2'd0:    n_lanes = 1;
            2'd1:    n_lanes = 4;
            default: n_lanes = 8;
        endcase
        if (n_lanes > MaxLanes) begin
            n_lanes = MaxLanes;
        end
        lane_mask_o = '0;
        for (int i = 0; i < MaxLanes; i++) begin
            lane_mask_o[i] = (i < n_lanes);
        end
    end

    // Timeout fires on the cycle the counter would reach a nonzero limit; extra bit avoids wrap.
    assign tmo_nxt = {1'b0, tmo_cnt} + {{TimeoutWidth{1'b0}}, 1'b1};
    assign tmo_hit = (tmo_lim_q != '0) && (tmo_nxt >= {1'b0, tmo_lim_q});
    assign buf_ok  = dir_q ? buf_space_i : buf_block_i;
    assign is_last = cnt_en_q && (blocks_left_o == BlockCntWidth'(1));

`ifndef DAT_XFER_BUSY_WAIT_EN
    logic unused_dat0;
    assign unused_dat0 = dat0_i;
`endif

    // Transfer sequencer: state, latched transfer parameters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            dir_q           <= 1'b0;
            cnt_en_q        <= 1'b0;
            blk_seen_q      <= 1'b0;
            tmo_lim_q       <= '0;
            tmo_cnt         <= '0;
            blk_start_o     <= 1'b0;
            pause_sd_clk_o  <= 1'b0;
            request_cmd12_o <= 1'b0;
            read_active_o   <= 1'b0;
            write_active_o  <= 1'b0;
            gap_stopped_o   <= 1'b0;
            xfer_done_o     <= 1'b0;
            crc_err_o       <= 1'b0;
            end_bit_err_o   <= 1'b0;
            timeout_err_o   <= 1'b0;
            blocks_left_o   <= '0;
        end else begin
            blk_start_o     <= 1'b0;
            request_cmd12_o <= 1'b0;
            xfer_done_o     <= 1'b0;
            crc_err_o       <= 1'b0;
            end_bit_err_o   <= 1'b0;
            timeout_err_o   <= 1'b0;

            if (abort_i && (state != S_IDLE)) begin
                // Abandon silently: no completion pulse, everything visible returns to idle.
                state          <= S_IDLE;
                read_active_o  <= 1'b0;
                write_active_o <= 1'b0;
                gap_stopped_o  <= 1'b0;
                pause_sd_clk_o <= 1'b0;
                blocks_left_o  <= '0;
                blk_seen_q     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (xfer_req_i) begin
                            dir_q         <= dir_read_i;
                            cnt_en_q      <= block_count_en_i;
                            blocks_left_o <= block_count_i;
                            tmo_lim_q     <= timeout_limit_i;
                            tmo_cnt       <= '0;
                            blk_seen_q    <= 1'b0;
                            if (block_count_en_i && (block_count_i == '0)) begin
                                state       <= S_DONE;
                                xfer_done_o <= 1'b1;
                            end else begin
                                state          <= S_WAIT_CMD;
                                read_active_o  <= dir_read_i;
                                write_active_o <= !dir_read_i;
                            end
                        end
                    end
                    S_WAIT_CMD: begin
                        if (dir_q ? cmd_done_i : rsp_done_i) begin
                            state          <= S_WAIT_BUF;
                            pause_sd_clk_o <= dir_q && blk_seen_q;
                        end
                    end
                    S_WAIT_BUF: begin
                        if (buf_ok) begin
                            state          <= S_START;
                            pause_sd_clk_o <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (sd_clk_en_p_i) begin
                            state       <= S_XFER;
                            blk_start_o <= 1'b1;
                            tmo_cnt     <= '0;
                        end
                    end
                    S_XFER: begin
                        tmo_cnt <= tmo_nxt[TimeoutWidth-1:0];
                        if (tmo_hit) begin
                            state         <= S_TIMEOUT;
                            timeout_err_o <= 1'b1;
                        end else if (blk_done_i) begin
                            state         <= S_BLK_DONE;
                            crc_err_o     <= blk_crc_err_i;
                            end_bit_err_o <= blk_end_err_i;
                        end
                    end
                    S_BLK_DONE: begin
                        blk_seen_q <= 1'b1;
                        if (cnt_en_q && (blocks_left_o != '0)) begin
                            blocks_left_o <= blocks_left_o - BlockCntWidth'(1);
                        end
                        if (is_last) begin
                            state           <= dir_q ? S_DRAIN : S_BUSY;
                            request_cmd12_o <= auto_cmd12_en_i;
                        end else if (stop_at_gap_i) begin
                            state         <= S_GAP_STOP;
                            gap_stopped_o <= 1'b1;
                        end else begin
                            state          <= S_WAIT_BUF;
                            pause_sd_clk_o <= dir_q;
                        end
                    end
                    S_GAP_STOP: begin
                        if (continue_i) begin
                            state          <= S_WAIT_BUF;
                            gap_stopped_o  <= 1'b0;
                            pause_sd_clk_o <= dir_q;
                        end
                    end
                    S_DRAIN: begin
                        if (buf_empty_i) begin
                            state          <= S_DONE;
                            xfer_done_o    <= 1'b1;
                            read_active_o  <= 1'b0;
                            write_active_o <= 1'b0;
                        end
                    end
                    S_BUSY: begin
`ifdef DAT_XFER_BUSY_WAIT_EN
                        tmo_cnt <= tmo_nxt[TimeoutWidth-1:0];
                        if (tmo_hit) begin
                            state         <= S_TIMEOUT;
                            timeout_err_o <= 1'b1;
                        end else if (dat0_i) begin
                            state          <= S_DONE;
                            xfer_done_o    <= 1'b1;
                            read_active_o  <= 1'b0;
                            write_active_o <= 1'b0;
                        end
`else
                        state          <= S_DONE;
                        xfer_done_o    <= 1'b1;
                        read_active_o  <= 1'b0;
                        write_active_o <= 1'b0;
`endif
                    end
                    S_TIMEOUT: begin
                        state          <= S_DONE;
                        xfer_done_o    <= 1'b1;
                        read_active_o  <= 1'b0;
                        write_active_o <= 1'b0;
                        gap_stopped_o  <= 1'b0;
                        pause_sd_clk_o <= 1'b0;
                    end
                    S_DONE: begin
                        state          <= S_IDLE;
                        read_active_o  <= 1'b0;
                        write_active_o <= 1'b0;
                        gap_stopped_o  <= 1'b0;
                        pause_sd_clk_o <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dat_xfer_seq.sv
// Randomized bench for dat_xfer_seq: emulated engine, buffer and command path around the DUT,
// with transfer-level expectations (block/pulse counts, latencies) derived from the block's rules.
module tb_dat_xfer_seq;

    localparam int MAXL = 4;
    localparam int BCW  = 16;
    localparam int TW   = 24;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            sd_clk_en_p_i;
    logic            xfer_req_i;
    logic            dir_read_i;
    logic            block_count_en_i;
    logic [BCW-1:0]  block_count_i;
    logic [1:0]      bus_width_i;
    logic            auto_cmd12_en_i;
    logic            stop_at_gap_i;
    logic            continue_i;
    logic            abort_i;
    logic            cmd_done_i;
    logic            rsp_done_i;
    logic [TW-1:0]   timeout_limit_i;
    logic            buf_space_i;
    logic            buf_block_i;
    logic            buf_empty_i;
    logic            dat0_i;
    logic            blk_start_o;
    logic            blk_done_i;
    logic            blk_crc_err_i;
    logic            blk_end_err_i;
    logic [MAXL-1:0] lane_mask_o;
    logic            pause_sd_clk_o;
    logic            request_cmd12_o;
    logic            read_active_o;
    logic            write_active_o;
    logic            gap_stopped_o;
    logic            xfer_done_o;
    logic            crc_err_o;
    logic            end_bit_err_o;
    logic            timeout_err_o;
    logic [BCW-1:0]  blocks_left_o;

    dat_xfer_seq #(.MaxLanes(MAXL), .BlockCntWidth(BCW), .TimeoutWidth(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sd_clk_en_p_i(sd_clk_en_p_i),
        .xfer_req_i(xfer_req_i), .dir_read_i(dir_read_i),
        .block_count_en_i(block_count_en_i), .block_count_i(block_count_i),
        .bus_width_i(bus_width_i), .auto_cmd12_en_i(auto_cmd12_en_i),
        .stop_at_gap_i(stop_at_gap_i), .continue_i(continue_i), .abort_i(abort_i),
        .cmd_done_i(cmd_done_i), .rsp_done_i(rsp_done_i),
        .timeout_limit_i(timeout_limit_i), .buf_space_i(buf_space_i),
        .buf_block_i(buf_block_i), .buf_empty_i(buf_empty_i), .dat0_i(dat0_i),
        .blk_start_o(blk_start_o), .blk_done_i(blk_done_i),
        .blk_crc_err_i(blk_crc_err_i), .blk_end_err_i(blk_end_err_i),
        .lane_mask_o(lane_mask_o), .pause_sd_clk_o(pause_sd_clk_o),
        .request_cmd12_o(request_cmd12_o), .read_active_o(read_active_o),
        .write_active_o(write_active_o), .gap_stopped_o(gap_stopped_o),
        .xfer_done_o(xfer_done_o), .crc_err_o(crc_err_o),
        .end_bit_err_o(end_bit_err_o), .timeout_err_o(timeout_err_o),
        .blocks_left_o(blocks_left_o)
    );

    always #5 clk_i = ~clk_i;

    // Environment controls, written only by the main sequence.
    int   buf_mode  = 0;   // 0 always ready, 1 random, 2 manual
    bit   man_space = 1'b1;
    bit   man_block = 1'b1;
    bit   man_empty = 1'b1;
    int   dat0_mode = 0;   // 0 random, 1 manual
    bit   man_dat0  = 1'b0;
    bit   eng_en    = 1'b1;
    bit   force_crc = 1'b0;

    // Event counters, written only by the monitor / engine processes.
    int n_start = 0, n_cmd12 = 0, n_done = 0, n_crc = 0, n_end = 0, n_tmo = 0;
    int n_dec = 0, bad_steps = 0, bad_pause = 0;
    int n_icrc = 0, n_iend = 0;
    int prev_bl = 0;
    int eng_cd = -1;
    bit cur_crc = 1'b0, cur_end = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Snapshots taken by the main sequence.
    int b_start, b_cmd12, b_done, b_crc, b_end, b_tmo, b_dec, b_icrc, b_iend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference lane mask: 1/4/8 lanes by code, 3 = widest, clipped to MAXL.
    function automatic logic [MAXL-1:0] exp_mask(input int bw);
        int l;
        l = (bw == 0) ? 1 : ((bw == 1) ? 4 : 8);
        if (l > MAXL) l = MAXL;
        return MAXL'((1 << l) - 1);
    endfunction

    task automatic take_snap();
        b_start = n_start; b_cmd12 = n_cmd12; b_done = n_done; b_crc = n_crc;
        b_end = n_end; b_tmo = n_tmo; b_dec = n_dec; b_icrc = n_icrc; b_iend = n_iend;
    endtask

    task automatic start_xfer(input bit dir, input bit cen, input int cnt, input bit a12,
                              input int lim);
        dir_read_i       = dir;
        block_count_en_i = cen;
        block_count_i    = BCW'(cnt);
        auto_cmd12_en_i  = a12;
        timeout_limit_i  = TW'(lim);
        xfer_req_i       = 1'b1;
        @(negedge clk_i);
        xfer_req_i       = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (xfer_done_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (blk_start_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    // SD clock enable: irregular posedge strobes.
    initial begin
        sd_clk_en_p_i = 1'b0;
        forever begin
            @(negedge clk_i);
            sd_clk_en_p_i = ($urandom_range(0, 2) == 0);
        end
    end

    // Command path: command-sent / response-received strobes at random.
    initial begin
        cmd_done_i = 1'b0;
        rsp_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            cmd_done_i = ($urandom_range(0, 3) == 0);
            rsp_done_i = ($urandom_range(0, 3) == 0);
        end
    end

    // Buffer status model.
    initial begin
        buf_space_i = 1'b1;
        buf_block_i = 1'b1;
        buf_empty_i = 1'b1;
        forever begin
            @(negedge clk_i);
            case (buf_mode)
                0: begin buf_space_i = 1'b1; buf_block_i = 1'b1; buf_empty_i = 1'b1; end
                1: begin
                    buf_space_i = ($urandom_range(0, 1) == 1);
                    buf_block_i = ($urandom_range(0, 1) == 1);
                    buf_empty_i = ($urandom_range(0, 2) == 0);
                end
                default: begin
                    buf_space_i = man_space; buf_block_i = man_block; buf_empty_i = man_empty;
                end
            endcase
        end
    end

    // DAT0 busy line.
    initial begin
        dat0_i = 1'b0;
        forever begin
            @(negedge clk_i);
            dat0_i = (dat0_mode == 0) ? ($urandom_range(0, 1) == 1) : man_dat0;
        end
    end

    // Block engine: finishes each started block after a short random delay, injecting errors.
    initial begin
        blk_done_i    = 1'b0;
        blk_crc_err_i = 1'b0;
        blk_end_err_i = 1'b0;
        forever begin
            @(negedge clk_i);
            blk_done_i    = 1'b0;
            blk_crc_err_i = 1'b0;
            blk_end_err_i = 1'b0;
            if (eng_cd > 0) begin
                eng_cd--;
            end else if (eng_cd == 0) begin
                blk_done_i    = 1'b1;
                blk_crc_err_i = cur_crc;
                blk_end_err_i = cur_end;
                if (cur_crc) n_icrc++;
                if (cur_end) n_iend++;
                eng_cd = -1;
            end
            if (eng_en && blk_start_o) begin
                eng_cd  = $urandom_range(1, 8);
                cur_crc = force_crc || ($urandom_range(0, 3) == 0);
                cur_end = ($urandom_range(0, 4) == 0);
            end
        end
    end

    // Monitor: counts output pulses and watches the block counter and clock-pause rule.
    initial begin
        forever begin
            @(negedge clk_i);
            if (blk_start_o)     n_start++;
            if (request_cmd12_o) n_cmd12++;
            if (xfer_done_o)     n_done++;
            if (crc_err_o)       n_crc++;
            if (end_bit_err_o)   n_end++;
            if (timeout_err_o)   n_tmo++;
            if (pause_sd_clk_o && !read_active_o) bad_pause++;
            if (int'(blocks_left_o) < prev_bl) begin
                n_dec++;
                if (int'(blocks_left_o) != prev_bl - 1) bad_steps++;
            end
            prev_bl = int'(blocks_left_o);
        end
    end

    initial begin
        bit ok;
        int lat;
        int seen;
        bit dir;
        bit a12;
        int cnt;
        int bw;

        rst_i = 1'b1;
        xfer_req_i = 1'b0; dir_read_i = 1'b0; block_count_en_i = 1'b0; block_count_i = '0;
        bus_width_i = 2'd0; auto_cmd12_en_i = 1'b0; stop_at_gap_i = 1'b0; continue_i = 1'b0;
        abort_i = 1'b0; timeout_limit_i = '0;
        repeat (3) @(negedge clk_i);

        // Reset state
        check("rst_pulses", 32'({blk_start_o, request_cmd12_o, xfer_done_o, crc_err_o,
                                 end_bit_err_o, timeout_err_o}), 32'd0);
        check("rst_levels", 32'({pause_sd_clk_o, read_active_o, write_active_o, gap_stopped_o}), 32'd0);
        check("rst_blocks", 32'(blocks_left_o), 32'd0);
        check("rst_mask", 32'(lane_mask_o), 32'd1);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Lane mask over every width code
        for (int w = 0; w < 4; w++) begin
            bus_width_i = 2'(w);
            #1;
            check("lane_mask", 32'(lane_mask_o), 32'(exp_mask(w)));
            @(negedge clk_i);
        end

        // Randomized counted transfers; first one is the 3-block read with auto CMD12
        for (int it = 0; it < 8; it++) begin
            dir      = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cnt      = (it == 0) ? 3 : int'($urandom_range(1, 4));
            a12      = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bw       = (it == 0) ? 1 : int'($urandom_range(0, 3));
            buf_mode = (it == 0) ? 0 : int'($urandom_range(0, 1));
            bus_width_i = 2'(bw);
            take_snap();
            start_xfer(dir, 1'b1, cnt, a12, 0);
            check("act_read", 32'(read_active_o), 32'(dir));
            check("act_write", 32'(write_active_o), 32'(!dir));
            check("blk_load", 32'(blocks_left_o), 32'(cnt));
            check("xfer_mask", 32'(lane_mask_o), 32'(exp_mask(bw)));
            wait_done(3000, ok);
            check("done_seen", 32'(ok), 32'd1);
            check("done_inactive", 32'({read_active_o, write_active_o}), 32'd0);
            check("blk_final", 32'(blocks_left_o), 32'd0);
            repeat (3) @(negedge clk_i);
            check("starts", 32'(n_start - b_start), 32'(cnt));
            check("decrements", 32'(n_dec - b_dec), 32'(cnt));
            check("cmd12", 32'(n_cmd12 - b_cmd12), 32'(a12));
            check("done_cnt", 32'(n_done - b_done), 32'd1);
            check("crc_cnt", 32'(n_crc - b_crc), 32'(n_icrc - b_icrc));
            check("endbit_cnt", 32'(n_end - b_end), 32'(n_iend - b_iend));
            check("no_tmo", 32'(n_tmo - b_tmo), 32'd0);
        end
        buf_mode = 0;
        bus_width_i = 2'd2;
        #1;
        check("mask_w8_clamp", 32'(lane_mask_o), 32'hF);
        @(negedge clk_i);

        // Zero-count counted transfer finishes without any block
        take_snap();
        start_xfer(1'b1, 1'b1, 0, 1'b1, 0);
        check("zero_done", 32'(xfer_done_o), 32'd1);
        check("zero_inactive", 32'({read_active_o, write_active_o}), 32'd0);
        repeat (3) @(negedge clk_i);
        check("zero_starts", 32'(n_start - b_start), 32'd0);
        check("zero_cmd12", 32'(n_cmd12 - b_cmd12), 32'd0);

        // Read stalls on a full buffer after block 1: SD clock paused until space returns
        buf_mode = 2; man_space = 1'b1; man_block = 1'b1; man_empty = 1'b1;
        take_snap();
        start_xfer(1'b1, 1'b1, 2, 1'b0, 0);
        wait_start(500, ok);
        check("pause_start1", 32'(ok), 32'd1);
        man_space = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (pause_sd_clk_o) begin seen = 1; break; end
            @(negedge clk_i);
        end
        check("pause_seen", 32'(seen), 32'd1);
        repeat (5) @(negedge clk_i);
        check("pause_held", 32'(pause_sd_clk_o), 32'd1);
        check("pause_one_start", 32'(n_start - b_start), 32'd1);
        check("pause_blocks", 32'(blocks_left_o), 32'd1);
        man_space = 1'b1;
        wait_done(2000, ok);
        check("pause_done", 32'(ok), 32'd1);
        check("pause_clear", 32'(pause_sd_clk_o), 32'd0);
        repeat (2) @(negedge clk_i);
        check("pause_two_starts", 32'(n_start - b_start), 32'd2);
        buf_mode = 0;

        // Infinite write: stop at the gap after block 2, continue, then abort
        take_snap();
        start_xfer(1'b0, 1'b0, 1, 1'b0, 0);
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            if (blk_start_o) seen++;
            if (seen == 2) break;
            @(negedge clk_i);
        end
        check("gap_two_starts", 32'(seen), 32'd2);
        stop_at_gap_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (gap_stopped_o) begin seen = 1; break; end
            @(negedge clk_i);
        end
        check("gap_stopped", 32'(seen), 32'd1);
        xfer_req_i = 1'b1;
        dir_read_i = 1'b1;
        @(negedge clk_i);
        xfer_req_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("gap_held", 32'(gap_stopped_o), 32'd1);
        check("gap_no_start", 32'(n_start - b_start), 32'd2);
        check("gap_req_ignored", 32'({read_active_o, write_active_o}), 32'b01);
        check("gap_no_count", 32'(blocks_left_o), 32'd1);
        stop_at_gap_i = 1'b0;
        continue_i = 1'b1;
        @(negedge clk_i);
        continue_i = 1'b0;
        wait_start(500, ok);
        check("gap_resume", 32'(ok), 32'd1);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_levels", 32'({read_active_o, write_active_o, gap_stopped_o, pause_sd_clk_o}), 32'd0);
        check("abort_blocks", 32'(blocks_left_o), 32'd0);
        repeat (20) @(negedge clk_i);
        check("abort_no_done", 32'(n_done - b_done), 32'd0);

        // Read timeout: engine never answers
        eng_en = 1'b0;
        take_snap();
        start_xfer(1'b1, 1'b1, 1, 1'b0, 100);
        wait_start(500, ok);
        check("tmo_start", 32'(ok), 32'd1);
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            lat++;
            if (timeout_err_o) break;
        end
        check("tmo_latency", 32'(lat), 32'd100);
        @(negedge clk_i);
        check("tmo_done", 32'(xfer_done_o), 32'd1);
        repeat (2) @(negedge clk_i);
        check("tmo_pulses", 32'(n_tmo - b_tmo), 32'd1);
        eng_en = 1'b1;
        repeat (5) @(negedge clk_i);

        // Single-block write with a CRC error; completion held by DAT0 busy when enabled
        force_crc = 1'b1;
`ifdef DAT_XFER_BUSY_WAIT_EN
        dat0_mode = 1;
        man_dat0  = 1'b0;
`endif
        take_snap();
        start_xfer(1'b0, 1'b1, 1, 1'b1, 0);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (crc_err_o) begin seen = 1; break; end
            @(negedge clk_i);
        end
        check("wcrc_pulse", 32'(seen), 32'd1);
`ifdef DAT_XFER_BUSY_WAIT_EN
        repeat (30) @(negedge clk_i);
        check("wcrc_busy_hold", 32'(n_done - b_done), 32'd0);
        man_dat0 = 1'b1;
`endif
        wait_done(500, ok);
        check("wcrc_done", 32'(ok), 32'd1);
        repeat (2) @(negedge clk_i);
        check("wcrc_count", 32'(n_crc - b_crc), 32'd1);
        check("wcrc_cmd12", 32'(n_cmd12 - b_cmd12), 32'd1);
        force_crc = 1'b0;
        dat0_mode = 0;

        check("block_steps", 32'(bad_steps), 32'd0);
        check("pause_only_read", 32'(bad_pause), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
